// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 2:1 round-robin word arbiter.
//   - State encoding of the output holding register
//   - Default data path and grant counter widths
//   - Winner selection helper (single request wins, ties rotate)
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 8;

    // Holding register state: which requester (if any) owns out_data.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD_A = 2'd1;
    localparam logic [1:0] ST_HOLD_B = 2'd2;

    // Returns 0 for A, 1 for B. With a single request that requester wins;
    // with both, the one that did not win last time wins. Meaningless when
    // neither requests; callers qualify it with (req_a | req_b).
    function automatic logic pick_winner(
        input logic req_a,
        input logic req_b,
        input logic last_sel
    );
        if (req_a && req_b) begin
            return ~last_sel;
        end
        return req_b;
    endfunction

endpackage

// File: rtl/data_sel_2_1.sv
// ---------------------------------------------------------------------------
// data_sel_2_1
// WIDTH-bit 2:1 data selector feeding the arbiter output register.
// Ports:
//   sel  - 0 selects a, 1 selects b
//   a, b - candidate words
//   y    - selected word (combinational)
// ---------------------------------------------------------------------------
module data_sel_2_1 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/arb_2_1_32.sv
// ---------------------------------------------------------------------------
// arb_2_1_32
// Two-requester round-robin arbiter with a single registered output word.
// A requester presents a word with req_x high; when the output register can
// take a word (empty, or being drained this cycle) the winner's gnt_x pulses
// and its word is captured on the next rising edge.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_a/data_a        - requester A valid + word
//   req_b/data_b        - requester B valid + word
//   gnt_a/gnt_b         - one-cycle capture pulse for A / B (combinational)
//   out_data/out_valid  - held word and its valid flag
//   out_ready           - consumer accepts out_data when out_valid is high
//   sel                 - owner of held word, 0=A 1=B
//   cnt_a/cnt_b         - free-running grant counters (wrap silently)
// ---------------------------------------------------------------------------
module arb_2_1_32
    import arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             last_sel_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [CNT_W-1:0] cnt_a_reg;
    logic [CNT_W-1:0] cnt_b_reg;

    logic             load;
    logic             do_load;
    logic             winner;
    logic [WIDTH-1:0] sel_data;

    // The register can take a new word when it is empty or is being drained
    // this cycle; this is what allows one word per cycle when out_ready stays
    // high.
    assign load    = (state_reg == ST_IDLE) || out_ready;
    assign winner  = pick_winner(req_a, req_b, last_sel_reg);
    assign do_load = load && (req_a || req_b);

    // Grants are masked by rst so nothing is acknowledged during reset.
    assign gnt_a = do_load && !winner && !rst;
    assign gnt_b = do_load &&  winner && !rst;

    data_sel_2_1 #(
        .WIDTH (WIDTH)
    ) u_data_sel (
        .sel (winner),
        .a   (data_a),
        .b   (data_b),
        .y   (sel_data)
    );

    always_comb begin
        state_next = state_reg;
        if (do_load) begin
            state_next = winner ? ST_HOLD_B : ST_HOLD_A;
        end else begin
            case (state_reg)
                ST_HOLD_A, ST_HOLD_B: if (out_ready) state_next = ST_IDLE;
                ST_IDLE:              state_next = ST_IDLE;
                default:              state_next = ST_IDLE; // 2'd3 recovery
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            last_sel_reg <= 1'b1;   // A wins the first tie after reset
            out_data_reg <= '0;
            cnt_a_reg    <= '0;
            cnt_b_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (do_load) begin
                out_data_reg <= sel_data;
                last_sel_reg <= winner;
            end
            if (gnt_a) cnt_a_reg <= cnt_a_reg + CNT_ONE;
            if (gnt_b) cnt_b_reg <= cnt_b_reg + CNT_ONE;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = (state_reg == ST_HOLD_A) || (state_reg == ST_HOLD_B);
    assign sel       = (state_reg == ST_HOLD_B);
    assign cnt_a     = cnt_a_reg;
    assign cnt_b     = cnt_b_reg;

endmodule

// File: tb/tb_arb_2_1_32.sv
// ---------------------------------------------------------------------------
// tb_arb_2_1_32
// Directed self-checking bench for arb_2_1_32. Inputs change 1 time unit
// after a rising edge; combinational grants are sampled 2 units after that,
// registered outputs 1 unit after the edge.
// ---------------------------------------------------------------------------
module tb_arb_2_1_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, out_ready;
    logic [31:0] data_a, data_b;
    logic        gnt_a, gnt_b, out_valid, sel;
    logic [31:0] out_data;
    logic [7:0]  cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arb_2_1_32 #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = 0; req_b = 0; out_ready = 0;
        data_a = '0; data_b = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; req_a = 1; req_b = 1; out_ready = 1;
        #2;
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            $display("FAIL reset_gnt: got %b expected 00", {gnt_a, gnt_b}); n_fail++;
        end
        n_checks++;
        if ({out_valid, sel, out_data, cnt_a, cnt_b} !== 50'd0) begin
            $display("FAIL reset_state: valid=%b sel=%b data=%h cnt_a=%0d cnt_b=%0d expected all 0",
                     out_valid, sel, out_data, cnt_a, cnt_b); n_fail++;
        end
        $display("test_reset: done");
        do_reset();
    endtask

    task automatic test_single();
        req_a = 1; data_a = 32'hDEADBEEF; out_ready = 1;
        #2;
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            $display("FAIL single_gnt: got %b expected 10", {gnt_a, gnt_b}); n_fail++;
        end
        step();
        req_a = 0;
        n_checks++;
        if ({out_valid, sel, out_data, cnt_a} !== {1'b1, 1'b0, 32'hDEADBEEF, 8'd1}) begin
            $display("FAIL single_out: valid=%b sel=%b data=%h cnt_a=%0d expected 1 0 deadbeef 1",
                     out_valid, sel, out_data, cnt_a); n_fail++;
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL single_drain: out_valid=%b expected 0", out_valid); n_fail++;
        end
        $display("test_single: word deadbeef transferred");
    endtask

    task automatic test_round_robin();
        logic        exp_w;
        logic [31:0] exp_d;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            req_a = 1; req_b = 1;
            data_a = 32'hA000_0000 + i;
            data_b = 32'hB000_0000 + i;
            exp_w = (i % 2 == 1);            // A,B,A,B,A,B
            exp_d = exp_w ? data_b : data_a;
            #2;
            n_checks++;
            if ({gnt_a, gnt_b} !== {~exp_w, exp_w}) begin
                $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt_a, gnt_b}, {~exp_w, exp_w});
                n_fail++;
            end
            step();
            n_checks++;
            if ({out_valid, sel, out_data} !== {1'b1, exp_w, exp_d}) begin
                $display("FAIL rr_out[%0d]: valid=%b sel=%b data=%h expected 1 %b %h",
                         i, out_valid, sel, out_data, exp_w, exp_d); n_fail++;
            end
            $display("test_round_robin: cycle %0d winner %s data %h", i, exp_w ? "B" : "A", out_data);
        end
        req_a = 0; req_b = 0;
        n_checks++;
        if ({cnt_a, cnt_b} !== {8'd3, 8'd3}) begin
            $display("FAIL rr_cnt: cnt_a=%0d cnt_b=%0d expected 3 3", cnt_a, cnt_b); n_fail++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        req_a = 1; data_a = 32'h1111_2222; out_ready = 1;
        step();
        out_ready = 0; req_b = 1; data_b = 32'h3333_4444;
        for (int i = 0; i < 4; i++) begin
            data_a = 32'h5555_0000 + i;
            #2;
            n_checks++;
            if ({gnt_a, gnt_b} !== 2'b00) begin
                $display("FAIL stall_gnt[%0d]: got %b expected 00", i, {gnt_a, gnt_b}); n_fail++;
            end
            step();
            n_checks++;
            if ({out_valid, sel, out_data} !== {1'b1, 1'b0, 32'h1111_2222}) begin
                $display("FAIL stall_hold[%0d]: valid=%b sel=%b data=%h expected 1 0 11112222",
                         i, out_valid, sel, out_data); n_fail++;
            end
        end
        out_ready = 1;
        #2;
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            $display("FAIL stall_release_gnt: got %b expected 01", {gnt_a, gnt_b}); n_fail++;
        end
        step();
        req_a = 0; req_b = 0;
        n_checks++;
        if ({out_valid, sel, out_data, cnt_a, cnt_b} !== {1'b1, 1'b1, 32'h3333_4444, 8'd1, 8'd1}) begin
            $display("FAIL stall_release_out: valid=%b sel=%b data=%h cnt=%0d/%0d expected 1 1 33334444 1/1",
                     out_valid, sel, out_data, cnt_a, cnt_b); n_fail++;
        end
        $display("test_stall: held 4 cycles then B loaded");
    endtask

    task automatic test_req_drop();
        // B held; A asks during a stall then withdraws before the slot opens.
        out_ready = 0; req_a = 1; data_a = 32'h7777_7777;
        step();
        req_a = 0; out_ready = 1;
        #2;
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            $display("FAIL drop_gnt: got %b expected 00", {gnt_a, gnt_b}); n_fail++;
        end
        step();
        n_checks++;
        if ({out_valid, cnt_a} !== {1'b0, 8'd1}) begin
            $display("FAIL drop_out: valid=%b cnt_a=%0d expected 0 1", out_valid, cnt_a); n_fail++;
        end
        $display("test_req_drop: withdrawn request not granted");
    endtask

    task automatic test_wrap();
        do_reset();
        req_a = 1; out_ready = 1;
        for (int i = 0; i < 256; i++) begin
            data_a = i;
            step();
            if (i == 254) begin
                n_checks++;
                if (cnt_a !== 8'd255) begin
                    $display("FAIL wrap_255: cnt_a=%0d expected 255", cnt_a); n_fail++;
                end
            end
        end
        req_a = 0;
        n_checks++;
        if ({cnt_a, cnt_b, out_data} !== {8'd0, 8'd0, 32'd255}) begin
            $display("FAIL wrap_0: cnt_a=%0d cnt_b=%0d data=%h expected 0 0 000000ff",
                     cnt_a, cnt_b, out_data); n_fail++;
        end
        $display("test_wrap: 256 grants to A, cnt_a=%0d", cnt_a);
    endtask

    task automatic test_async_reset();
        do_reset();
        req_b = 1; data_b = 32'hCAFE_F00D; out_ready = 1;
        step();
        out_ready = 0;
        req_a = 1; data_a = 32'hAAAA_0001;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_data, cnt_a, cnt_b, gnt_a, gnt_b} !== 51'd0) begin
            $display("FAIL async_rst: valid=%b data=%h cnt=%0d/%0d gnt=%b%b expected all 0",
                     out_valid, out_data, cnt_a, cnt_b, gnt_a, gnt_b); n_fail++;
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            $display("FAIL async_first_gnt: got %b expected 10", {gnt_a, gnt_b}); n_fail++;
        end
        step();
        req_a = 0; req_b = 0;
        n_checks++;
        if ({out_valid, sel, out_data, cnt_a, cnt_b} !== {1'b1, 1'b0, 32'hAAAA_0001, 8'd1, 8'd0}) begin
            $display("FAIL async_first_out: valid=%b sel=%b data=%h cnt=%0d/%0d expected 1 0 aaaa0001 1/0",
                     out_valid, sel, out_data, cnt_a, cnt_b); n_fail++;
        end
        $display("test_async_reset: held word dropped, A granted first");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_req_drop();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
